// File: rtl/program_counter_unit.sv
// program_counter_unit
// Fetch PC sequencer: steps by instruction length, follows branch/jump
// redirects, returns through a circular return-address stack and vectors
// to a trap handler on misaligned targets or RAS underflow. A second fault
// while the handler runs parks the unit in HALT until reset.
module program_counter_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0010),
   parameter int unsigned     IALIGN       = 32,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            advance,
   input  logic            short_inst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            push,
   input  logic            pop,
   input  logic            trap_return,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] epc,
   output logic [1:0]      cause,
   output logic            trap,
   output logic            in_trap,
   output logic            halted,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] CAUSE_NONE      = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN  = 2'd1;
   localparam logic [1:0] CAUSE_UNDERFLOW = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [XLEN-1:0]   pc_r, pc_s;
   logic [XLEN-1:0]   epc_r, epc_s;
   logic [1:0]        cause_r, cause_s;
   logic              trap_r, trap_s;
   logic [PTR_W-1:0]  top_r, top_s;
   logic [CNT_W-1:0]  count_r, count_s;
   logic [XLEN-1:0]   ras_mem_r [RAS_DEPTH];

   logic              ras_we_s;
   logic [PTR_W-1:0]  ras_waddr_s;
   logic [XLEN-1:0]   len_s;
   logic [XLEN-1:0]   ret_addr_s;
   logic [XLEN-1:0]   ras_top_s;
   logic              ras_empty_s;

   logic              sel_fault_s;
   logic [1:0]        sel_code_s;
   logic [XLEN-1:0]   sel_pc_s;
   logic              sel_pop_s;
   logic              sel_leave_s;

   // Alignment rule for any PC target: 4-byte without compressed support, 2-byte with it.
   function automatic logic misaligned(input logic [XLEN-1:0] addr);
      if (IALIGN == 16) begin
         misaligned = addr[0];
      end else begin
         misaligned = (addr[1:0] != 2'b00);
      end
   endfunction

   assign len_s       = (IALIGN == 16 && short_inst) ? XLEN'(32'd2) : XLEN'(32'd4);
   assign ret_addr_s  = pc_r + len_s;
   assign ras_top_s   = ras_mem_r[top_r];
   assign ras_empty_s = (count_r == CNT_W'(1'b0));

   // Pick the next-PC source by priority and flag a fault on a bad target or empty RAS.
   always_comb begin
      sel_fault_s = 1'b0;
      sel_code_s  = CAUSE_NONE;
      sel_pc_s    = pc_r;
      sel_pop_s   = 1'b0;
      sel_leave_s = 1'b0;
      if (trap_return && state_r == ST_TRAP) begin
         sel_leave_s = 1'b1;
         if (misaligned(epc_r)) begin
            sel_fault_s = 1'b1;
            sel_code_s  = CAUSE_MISALIGN;
         end else begin
            sel_pc_s = epc_r;
         end
      end else if (pop) begin
         if (ras_empty_s) begin
            sel_fault_s = 1'b1;
            sel_code_s  = CAUSE_UNDERFLOW;
         end else if (misaligned(ras_top_s)) begin
            sel_fault_s = 1'b1;
            sel_code_s  = CAUSE_MISALIGN;
         end else begin
            sel_pc_s  = ras_top_s;
            sel_pop_s = 1'b1;
         end
      end else if (redirect) begin
         if (misaligned(redirect_target)) begin
            sel_fault_s = 1'b1;
            sel_code_s  = CAUSE_MISALIGN;
         end else begin
            sel_pc_s = redirect_target;
         end
      end else if (advance) begin
         sel_pc_s = ret_addr_s;
      end else begin
         sel_pc_s = pc_r;
      end
   end

   // FSM next state, PC/trap bookkeeping and RAS pointer/count update.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      epc_s       = epc_r;
      cause_s     = cause_r;
      trap_s      = 1'b0;
      top_s       = top_r;
      count_s     = count_r;
      ras_we_s    = 1'b0;
      ras_waddr_s = top_r;
      case (state_r)
         ST_RUN, ST_TRAP: begin
            if (sel_fault_s) begin
               // A fault leaves the RAS untouched and drops any coincident push.
               cause_s = sel_code_s;
               if (state_r == ST_RUN) begin
                  pc_s    = TRAP_VECTOR;
                  epc_s   = pc_r;
                  state_s = ST_TRAP;
                  trap_s  = 1'b1;
               end else begin
                  state_s = ST_HALT;
               end
            end else begin
               pc_s = sel_pc_s;
               if (sel_leave_s) begin
                  state_s = ST_RUN;
                  cause_s = CAUSE_NONE;
               end else begin
                  state_s = state_r;
               end
               if (sel_pop_s && push) begin
                  // Return and call together: replace the top in place.
                  ras_we_s    = 1'b1;
                  ras_waddr_s = top_r;
               end else if (sel_pop_s) begin
                  top_s   = top_r - PTR_W'(1'b1);
                  count_s = count_r - CNT_W'(1'b1);
               end else if (push) begin
                  // When full, top+1 is the oldest slot, so it is overwritten.
                  ras_we_s    = 1'b1;
                  ras_waddr_s = top_r + PTR_W'(1'b1);
                  top_s       = top_r + PTR_W'(1'b1);
                  if (count_r != CNT_W'(RAS_DEPTH)) begin
                     count_s = count_r + CNT_W'(1'b1);
                  end else begin
                     count_s = count_r;
                  end
               end else begin
                  top_s = top_r;
               end
            end
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_HALT;
         end
      endcase
   end

   // Architectural state and outputs, cleared asynchronously by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_RUN;
         pc_r    <= RESET_VECTOR;
         epc_r   <= XLEN'(32'd0);
         cause_r <= CAUSE_NONE;
         trap_r  <= 1'b0;
         top_r   <= PTR_W'(1'b0);
         count_r <= CNT_W'(1'b0);
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         epc_r   <= epc_s;
         cause_r <= cause_s;
         trap_r  <= trap_s;
         top_r   <= top_s;
         count_r <= count_s;
      end
   end

   // Return-address storage; contents are meaningless while count is zero.
   always_ff @(posedge clock) begin
      if (ras_we_s) begin
         ras_mem_r[ras_waddr_s] <= ret_addr_s;
      end
   end

   assign pc        = pc_r;
   assign epc       = epc_r;
   assign cause     = cause_r;
   assign trap      = trap_r;
   assign in_trap   = (state_r == ST_TRAP);
   assign halted    = (state_r == ST_HALT);
   assign ras_empty = ras_empty_s;
   assign ras_full  = (count_r == CNT_W'(RAS_DEPTH));

endmodule

// File: tb/tb_program_counter_unit.sv
// tb_program_counter_unit
// Drives a 4-byte-aligned and a 2-byte-aligned instance with identical
// strobes; a queue-based reference model predicts every output each cycle.
module tb_program_counter_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        advance, short_inst, redirect, push, pop, trap_return;
   logic [31:0] redirect_target;

   logic [31:0] pc32, epc32, pc16, epc16;
   logic [1:0]  cause32, cause16;
   logic        trap32, in_trap32, halted32, ras_empty32, ras_full32;
   logic        trap16, in_trap16, halted16, ras_empty16, ras_full16;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: index 0 = IALIGN 32, index 1 = IALIGN 16.
   logic [31:0] m_pc [2];
   logic [31:0] m_epc [2];
   logic [1:0]  m_cause [2];
   logic        m_trap [2];
   int          m_st [2];          // 0 run, 1 trap handler, 2 halted
   logic [31:0] ras0 [$];
   logic [31:0] ras1 [$];

   localparam logic [31:0] TVEC = 32'h10;

   program_counter_unit #(.IALIGN(32)) u_d32 (
      .clock(clock), .reset(reset), .advance(advance), .short_inst(short_inst),
      .redirect(redirect), .redirect_target(redirect_target), .push(push), .pop(pop),
      .trap_return(trap_return), .pc(pc32), .epc(epc32), .cause(cause32), .trap(trap32),
      .in_trap(in_trap32), .halted(halted32), .ras_empty(ras_empty32), .ras_full(ras_full32));

   program_counter_unit #(.IALIGN(16)) u_d16 (
      .clock(clock), .reset(reset), .advance(advance), .short_inst(short_inst),
      .redirect(redirect), .redirect_target(redirect_target), .push(push), .pop(pop),
      .trap_return(trap_return), .pc(pc16), .epc(epc16), .cause(cause16), .trap(trap16),
      .in_trap(in_trap16), .halted(halted16), .ras_empty(ras_empty16), .ras_full(ras_full16));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic misal(input int k, input logic [31:0] a);
      return (k == 1) ? a[0] : (a[1:0] != 2'b00);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_cause[k] = 2'd0; m_trap[k] = 1'b0; m_st[k] = 0;
      end
      ras0.delete();
      ras1.delete();
   endtask

   // One clock of the architectural rules, using the strobes currently driven.
   task automatic mstep(input int k);
      logic [31:0] q [$];
      logic [31:0] len, ret, npc;
      logic        flt, leave, dpop;
      logic [1:0]  code;
      if (k == 0) q = ras0; else q = ras1;
      m_trap[k] = 1'b0;
      if (m_st[k] == 2) return;
      len = (k == 1 && short_inst) ? 32'd2 : 32'd4;
      ret = m_pc[k] + len;
      flt = 1'b0; code = 2'd0; leave = 1'b0; dpop = 1'b0; npc = m_pc[k];
      if (trap_return && m_st[k] == 1) begin
         leave = 1'b1;
         if (misal(k, m_epc[k])) begin flt = 1'b1; code = 2'd1; end
         else npc = m_epc[k];
      end else if (pop) begin
         if (q.size() == 0) begin flt = 1'b1; code = 2'd2; end
         else if (misal(k, q[$])) begin flt = 1'b1; code = 2'd1; end
         else begin npc = q[$]; dpop = 1'b1; end
      end else if (redirect) begin
         if (misal(k, redirect_target)) begin flt = 1'b1; code = 2'd1; end
         else npc = redirect_target;
      end else if (advance) begin
         npc = ret;
      end
      if (flt) begin
         m_cause[k] = code;
         if (m_st[k] == 0) begin
            m_epc[k] = m_pc[k]; m_pc[k] = TVEC; m_st[k] = 1; m_trap[k] = 1'b1;
         end else begin
            m_st[k] = 2;
         end
      end else begin
         if (dpop) void'(q.pop_back());
         if (push) begin
            q.push_back(ret);
            if (q.size() > 4) void'(q.pop_front());
         end
         m_pc[k] = npc;
         if (leave) begin m_st[k] = 0; m_cause[k] = 2'd0; end
      end
      if (k == 0) ras0 = q; else ras1 = q;
   endtask

   task automatic check_all();
      chk("d32 pc", pc32, m_pc[0]);
      chk("d32 epc", epc32, m_epc[0]);
      chk("d32 cause", 32'(cause32), 32'(m_cause[0]));
      chk("d32 trap", 32'(trap32), 32'(m_trap[0]));
      chk("d32 in_trap", 32'(in_trap32), 32'(m_st[0] == 1));
      chk("d32 halted", 32'(halted32), 32'(m_st[0] == 2));
      chk("d32 ras_empty", 32'(ras_empty32), 32'(ras0.size() == 0));
      chk("d32 ras_full", 32'(ras_full32), 32'(ras0.size() == 4));
      chk("d16 pc", pc16, m_pc[1]);
      chk("d16 epc", epc16, m_epc[1]);
      chk("d16 cause", 32'(cause16), 32'(m_cause[1]));
      chk("d16 trap", 32'(trap16), 32'(m_trap[1]));
      chk("d16 in_trap", 32'(in_trap16), 32'(m_st[1] == 1));
      chk("d16 halted", 32'(halted16), 32'(m_st[1] == 2));
      chk("d16 ras_empty", 32'(ras_empty16), 32'(ras1.size() == 0));
      chk("d16 ras_full", 32'(ras_full16), 32'(ras1.size() == 4));
   endtask

   task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] t,
                        input logic pu, input logic po, input logic tr);
      advance = a; short_inst = s; redirect = r; redirect_target = t;
      push = pu; pop = po; trap_return = tr;
   endtask

   task automatic tick();
      mstep(0);
      mstep(1);
      @(posedge clock);
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic mid_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst pc", pc16, 32'h0);
      chk("rst halted", 32'(halted32), 32'h0);
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic [31:0] r, t;
      reset = 1'b1;
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      model_reset();
      #12;
      check_all();
      chk("reset ras_empty", 32'(ras_empty32), 32'h1);
      reset = 1'b0;

      // Plain stepping and wrap-around.
      drive(1, 0, 0, 32'h0, 0, 0, 0);
      tick(); chk("adv1 pc", pc32, 32'd4);
      tick(); chk("adv2 pc", pc32, 32'd8);
      tick(); chk("adv3 pc", pc32, 32'd12);
      drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      tick();
      drive(1, 0, 0, 32'h0, 0, 0, 0);
      tick(); chk("wrap pc32", pc32, 32'h0); chk("wrap pc16", pc16, 32'h0);

      // Short steps only count on the 2-byte-aligned instance.
      drive(1, 1, 0, 32'h0, 0, 0, 0);
      tick(); chk("short pc16", pc16, 32'd2); chk("short pc32", pc32, 32'd4);
      drive(1, 0, 0, 32'h0, 0, 0, 0);
      tick(); chk("long pc16", pc16, 32'd6);
      drive(0, 0, 1, 32'h101, 0, 0, 0);
      tick();
      chk("mis pc", pc16, 32'h10); chk("mis epc", epc16, 32'd6);
      chk("mis cause", 32'(cause16), 32'd1); chk("mis trap", 32'(trap16), 32'd1);
      drive(0, 0, 0, 32'h0, 0, 0, 0);
      tick(); chk("trap pulse end", 32'(trap16), 32'd0); chk("still in_trap", 32'(in_trap16), 32'd1);
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      tick(); chk("tret pc16", pc16, 32'd6); chk("tret cause", 32'(cause16), 32'd0);

      // Call and return.
      drive(0, 0, 1, 32'h20, 0, 0, 0);
      tick();
      drive(0, 0, 1, 32'h80, 1, 0, 0);
      tick(); chk("call pc", pc32, 32'h80);
      drive(0, 0, 0, 32'h0, 0, 1, 0);
      tick(); chk("ret pc", pc32, 32'h24); chk("ret empty", 32'(ras_empty32), 32'd1);

      // Overfill the RAS, then drain it to underflow.
      drive(0, 0, 1, 32'h100, 0, 0, 0);
      tick();
      drive(1, 0, 0, 32'h0, 1, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("full", 32'(ras_full32), 32'd1);
      drive(0, 0, 0, 32'h0, 0, 1, 0);
      tick(); chk("pop1", pc32, 32'h114);
      tick(); chk("pop2", pc32, 32'h110);
      tick(); chk("pop3", pc32, 32'h10C);
      tick(); chk("pop4", pc32, 32'h108);
      tick(); chk("uflow cause", 32'(cause32), 32'd2); chk("uflow pc", pc32, 32'h10);

      // Second fault halts; halted unit ignores everything.
      drive(0, 0, 1, 32'h3, 0, 0, 0);
      tick(); chk("halt", 32'(halted32), 32'd1); chk("halt cause", 32'(cause32), 32'd1);
      for (int i = 0; i < 10; i++) begin
         r = $urandom;
         drive(r[0], r[1], r[2], $urandom, r[3], r[4], r[5]);
         tick(); chk("frozen pc", pc32, 32'h10);
      end
      mid_reset();

      // Trap and return to the faulting PC, then reset mid-sequence.
      drive(0, 0, 1, 32'h40, 0, 0, 0);
      tick();
      drive(0, 0, 1, 32'h41, 0, 0, 0);
      tick(); chk("t40 epc", epc32, 32'h40);
      drive(0, 0, 0, 32'h0, 0, 0, 1);
      tick(); chk("t40 ret pc", pc32, 32'h40); chk("t40 in_trap", 32'(in_trap32), 32'd0);
      drive(1, 0, 0, 32'h0, 1, 0, 0);
      tick();
      tick();
      mid_reset();

      // Randomised strobes and targets against the model.
      for (int i = 0; i < 600; i++) begin
         r = $urandom;
         t = $urandom;
         if (r[17:16] != 2'b00) t[1:0] = 2'b00;
         else if (r[18]) t[1:0] = 2'b10;
         drive(r[0] | r[1], r[2], r[5:3] == 3'd0, t, r[8:6] == 3'd0,
               r[11:9] == 3'd0, r[13:12] == 2'd0);
         tick();
         if ((i % 60) == 59 || (m_st[0] == 2 && m_st[1] == 2)) mid_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Parametrised successor to the core's single-register program counter. Holds the fetch PC and sequences it by instruction length, branch/jump redirect, return-address-stack (RAS) pop or trap return. Detects misaligned targets and RAS underflow, vectoring to a trap handler with a saved exception PC, and escalating to a halted state on a double fault. Sits between the control unit (which raises the step/redirect strobes) and instruction fetch (which consumes `pc`).

## Interface
- `XLEN`, 32, PC and target width (≥ 8).
- `RESET_VECTOR`, 0, PC value after reset.
- `TRAP_VECTOR`, 'h10, PC loaded on a trap; must be IALIGN-aligned.
- `IALIGN`, 32, instruction alignment in bits; 16 enables 2-byte steps.
- `RAS_DEPTH`, 4, return-address-stack entries (power of two, 2–16).

Ports:
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `advance`  in  1  step PC to pc + length.
- `short_inst`  in  1  length is 2 when high and IALIGN=16; otherwise length is 4 (ignored when IALIGN=32).
- `redirect`  in  1  load `redirect_target`.
- `redirect_target`  in  XLEN  jump/branch target.
- `push`  in  1  push pc + length onto the RAS (call).
- `pop`  in  1  load RAS top and remove it (return).
- `trap_return`  in  1  load `epc`, leave the trap state.
- `pc`  out  XLEN  current PC; reset RESET_VECTOR.
- `epc`  out  XLEN  PC of the faulting instruction; reset 0.
- `cause`  out  2  0 none, 1 misaligned target, 2 RAS underflow; reset 0.
- `trap`  out  1  one-cycle pulse in the cycle after a trap is taken; reset 0.
- `in_trap`  out  1  state is TRAP; reset 0.
- `halted`  out  1  state is HALT; reset 0.
- `ras_empty`  out  1  reset 1.
- `ras_full`  out  1  reset 0.

## Operation
- FSM states: RUN (reset state), TRAP, HALT.
- Next-PC source, highest priority first: `trap_return`, then `pop`, then `redirect`, then `advance`, otherwise hold.
- length = 2 if (IALIGN=16 && `short_inst`), else 4.
- Arithmetic is mod 2^XLEN; pc + length wraps with no flag.
- Misaligned: target[1:0] ≠ 0 for IALIGN=32; target[0] ≠ 0 for IALIGN=16. The check applies to `redirect_target`, the popped RAS value and `epc` on trap return.
- Fault events:
  - a misaligned selected target;
  - `pop` with `ras_empty`.
- On a fault in RUN:
  - pc ← TRAP_VECTOR, epc ← current pc, cause ← code;
  - state → TRAP, `trap` pulses;
  - RAS is unchanged, and a coincident `push` is discarded.
- On a fault in TRAP: state → HALT, cause updated, pc/epc frozen.
- `trap_return` in TRAP with aligned epc: pc ← epc, state → RUN, cause ← 0.
- `trap_return` in RUN is ignored; the next priority source is used.
- All other sources operate normally in TRAP, so handler code runs, including calls and returns.
- HALT ignores every input until reset.
- RAS push:
  - writes pc + length (the pre-update pc) at top;
  - when full, overwrites the oldest entry circularly and the count stays at RAS_DEPTH.
- Simultaneous `pop` + `push` with a non-empty RAS: pc ← old top, top entry replaced by pc + length, count unchanged.
- `push` + `redirect` (call): redirect taken, return address pushed.
- `ras_empty` = (count = 0); `ras_full` = (count = RAS_DEPTH).

## Timing
- Every input is sampled at the rising edge; `pc` reflects the selected source one cycle later (latency 1, no combinational input→pc path).
- `trap` asserts in the cycle in which `pc` = TRAP_VECTOR and lasts exactly one cycle.
- `reset` asserted mid-operation immediately forces every output to its reset value and clears the RAS count; RAS contents are don't-care.
- No handshake: strobes are single-cycle qualifiers, and a strobe held high acts again every cycle.

## Test plan
- Reset, then `advance` ×3 with IALIGN=32 → pc 0, 4, 8, 12; pc = 'hFFFFFFFC + advance → 0.
- IALIGN=16, `advance`+`short_inst`, then `advance` → pc 2, then 6; `redirect` to 'h101 → pc 'h10, epc 6, cause 1, `trap` pulse, `in_trap` 1.
- From pc 'h20: `push`+`redirect`('h80), then `pop` → pc 'h80, then 'h24; `ras_empty` returns to 1.
- 5 pushes with RAS_DEPTH=4 → `ras_full`; 4 pops return the newest four addresses; the 5th pop traps with cause 2.
- In TRAP, `redirect` to 'h3 → `halted` 1, pc frozen across 10 cycles of random strobes; then `reset` → pc RESET_VECTOR, `halted` 0.
- Trap at pc 'h40, then `trap_return` → pc 'h40, cause 0, `in_trap` 0; assert `reset` mid-sequence → all outputs at reset values in the same cycle.
